// File: rtl/game_pkg.sv
// Shared constants and FSM state type for the falling-obstacle game logic.
// Imported by obstacle_spawner; the sub-module lfsr10 does not depend on it.
package game_pkg;

    localparam int SCREEN_W_DEF = 640;
    localparam int SCREEN_H_DEF = 480;
    localparam int OBS_W_DEF    = 32;
    localparam int OBS_H_DEF    = 32;
    localparam int PLAYER_W_DEF = 32;
    localparam int PLAYER_H_DEF = 32;

    localparam logic [9:0] LFSR_SEED = 10'h001;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_SPAWN = 3'd2,
        ST_FALL  = 3'd3,
        ST_OVER  = 3'd4
    } game_state_e;

endpackage

// File: rtl/lfsr10.sv
// Free-running 10-bit Fibonacci LFSR, polynomial x^10 + x^7 + 1.
// Maximal length, so it never reaches the all-zero lock-up state.
module lfsr10 (
    input  logic       clk,
    input  logic       reset,
    output logic [9:0] out
);

    logic [9:0] lfsr_q;
    logic [9:0] lfsr_d;

    assign lfsr_d = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
    assign out    = lfsr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= 10'h001;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/obstacle_spawner.sv
// Spawns one obstacle at a pseudo-random column, drops it once per frame and
// scores or ends the game. Optional macro OBSTACLE_SPEEDUP_EN: step grows with score.
module obstacle_spawner
    import game_pkg::*;
#(
    parameter int         SCREEN_W     = SCREEN_W_DEF,
    parameter int         SCREEN_H     = SCREEN_H_DEF,
    parameter int         OBS_W        = OBS_W_DEF,
    parameter int         OBS_H        = OBS_H_DEF,
    parameter int         PLAYER_W     = PLAYER_W_DEF,
    parameter int         PLAYER_H     = PLAYER_H_DEF,
    parameter int         SPAWN_FRAMES = 30,
    parameter logic [2:0] STEP_INIT    = 3'd2
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       start,
    input  logic       vsync,
    input  logic [9:0] player_x,
    input  logic [9:0] player_y,
    output logic [9:0] obstacle_x,
    output logic [9:0] obstacle_y,
    output logic       obstacle_active,
    output logic [6:0] score,
    output logic       game_over
);

    localparam int CNT_W = $clog2(SPAWN_FRAMES + 1);

    // state_q is the debug view of the FSM for checkers bound to this block.
    game_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [9:0]  obs_x_q, obs_x_d;
    logic [9:0]  obs_y_q, obs_y_d;
    logic        active_q, active_d;
    logic [6:0]  score_q, score_d;
    logic        over_q, over_d;
    logic        vsync_q;
    logic        tick;
    logic [9:0]  lfsr;
    logic [9:0]  spawn_x;
    logic [2:0]  step;
    logic [10:0] new_y;
    logic        overlap;
    logic [10:0] ox, oy, px, py;

    lfsr10 u_lfsr (
        .clk   (CLOCK_50),
        .reset (reset),
        .out   (lfsr)
    );

    assign tick = vsync_q & ~vsync;

    // Values past the last legal column fold back into the screen.
    assign spawn_x = (lfsr <= 10'(SCREEN_W - OBS_W)) ? lfsr : (lfsr - 10'd512);

    assign ox = {1'b0, obs_x_q};
    assign oy = {1'b0, obs_y_q};
    assign px = {1'b0, player_x};
    assign py = {1'b0, player_y};

    assign overlap = (ox < px + 11'(PLAYER_W)) && (px < ox + 11'(OBS_W)) &&
                     (oy < py + 11'(PLAYER_H)) && (py < oy + 11'(OBS_H));

`ifdef OBSTACLE_SPEEDUP_EN
    logic [4:0] step_sum;
    assign step_sum = {2'b00, STEP_INIT} + {1'b0, score_q[6:3]};
    assign step     = (step_sum > 5'd7) ? 3'd7 : step_sum[2:0];
`else
    assign step = STEP_INIT;
`endif

    assign new_y = oy + {8'b0, step};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        obs_x_d  = obs_x_q;
        obs_y_d  = obs_y_q;
        active_d = active_q;
        score_d  = score_q;
        over_d   = over_q;
        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start) begin
                    state_d  = ST_WAIT;
                    cnt_d    = '0;
                    score_d  = '0;
                    over_d   = 1'b0;
                    // A frozen obstacle from the last game is hidden on restart.
                    active_d = 1'b0;
                end
            end
            ST_WAIT: begin
                if (tick) begin
                    if (cnt_q == CNT_W'(SPAWN_FRAMES - 1)) begin
                        state_d = ST_SPAWN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_SPAWN: begin
                obs_x_d  = spawn_x;
                obs_y_d  = '0;
                active_d = 1'b1;
                state_d  = ST_FALL;
            end
            ST_FALL: begin
                if (tick) begin
                    // Collision is judged on the pre-move position and beats an exit.
                    if (overlap) begin
                        state_d = ST_OVER;
                        over_d  = 1'b1;
                    end else begin
                        obs_y_d = new_y[9:0];
                        if (new_y >= 11'(SCREEN_H)) begin
                            active_d = 1'b0;
                            score_d  = (score_q == 7'd127) ? score_q : score_q + 7'd1;
                            cnt_d    = '0;
                            state_d  = ST_WAIT;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            obs_x_q  <= '0;
            obs_y_q  <= '0;
            active_q <= 1'b0;
            score_q  <= '0;
            over_q   <= 1'b0;
            vsync_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            obs_x_q  <= obs_x_d;
            obs_y_q  <= obs_y_d;
            active_q <= active_d;
            score_q  <= score_d;
            over_q   <= over_d;
            vsync_q  <= vsync;
        end
    end

    assign obstacle_x      = obs_x_q;
    assign obstacle_y      = obs_y_q;
    assign obstacle_active = active_q;
    assign score           = score_q;
    assign game_over       = over_q;

endmodule
